netwalk_tcam_match_resolver: RTL

- Downstream stage of the TCAM unit array. Collects the per-unit match lines (one `of_matched_addr_out` bit per `tcam_unit`, lowest index = highest priority) for each search.
- Resolves each search into a single winning flow-table address plus a hit/miss flag.
- Buffers results in a small FIFO and hands them to the action-lookup stage over a valid/ready handshake.
- Maintains saturating hit and miss statistics counters.

---
 rtl/netwalk_tcam_match_resolver.sv | 124 ++++++++++++
 1 files changed

// File: rtl/netwalk_tcam_match_resolver.sv
// netwalk_tcam_match_resolver: priority-resolves TCAM match lines into a buffered hit/address result stream with statistics
module netwalk_tcam_match_resolver #(
  parameter int NUM_UNITS       = 16,
  parameter int TCAM_ADDR_WIDTH = 10,
  parameter int TCAM_BASE_ADDR  = 0,
  parameter int TAG_WIDTH       = 8,
  parameter int FIFO_DEPTH      = 4,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       srch_valid,
  output logic                       srch_ready,
  input  logic [NUM_UNITS-1:0]       srch_match_lines,
  input  logic [TAG_WIDTH-1:0]       srch_tag,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic                       res_hit,
  output logic [TCAM_ADDR_WIDTH-1:0] res_addr,
  output logic                       res_multi,
  output logic [TAG_WIDTH-1:0]       res_tag,
  input  logic                       stats_clear,
  output logic [CNT_WIDTH-1:0]       hit_count,
  output logic [CNT_WIDTH-1:0]       miss_count
);
  localparam int IW = $clog2(NUM_UNITS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = TCAM_ADDR_WIDTH + TAG_WIDTH + 2;

  logic                       s1_valid, s2_valid, s2_hit, s2_multi;
  logic [NUM_UNITS-1:0]       s1_lines;
  logic [TAG_WIDTH-1:0]       s1_tag, s2_tag;
  logic [TCAM_ADDR_WIDTH-1:0] s2_addr, enc_addr;
  logic [IW-1:0]              enc_idx;
  logic                       enc_hit, enc_multi;
  logic [EW-1:0]              mem [FIFO_DEPTH];
  logic [PW-1:0]              wr_ptr, rd_ptr;
  logic [PW:0]                count;
  logic [PW+1:0]              credits;
  logic                       accept, pop;

  assign accept  = srch_valid && srch_ready;
  assign pop     = res_valid && res_ready;
  assign res_valid = count != '0;
  // Outstanding work includes searches still in the pipe, so a granted search always has a FIFO slot waiting.
  assign credits = (PW+2)'(count) + (PW+2)'(s1_valid) + (PW+2)'(s2_valid);
  assign srch_ready = credits < (PW+2)'(FIFO_DEPTH);
  assign enc_hit   = |s1_lines;
  assign enc_multi = |(s1_lines & (s1_lines - NUM_UNITS'(1)));
  assign enc_addr  = enc_hit ? TCAM_ADDR_WIDTH'(TCAM_BASE_ADDR) + TCAM_ADDR_WIDTH'(enc_idx) : '0;
  assign {res_hit, res_addr, res_multi, res_tag} = res_valid ? mem[rd_ptr] : '0;

  // Lowest set match line wins; scanning downward lets the lowest index overwrite.
  always_comb begin
    enc_idx = '0;
    for (int i = NUM_UNITS - 1; i >= 0; i--) if (s1_lines[i]) enc_idx = IW'(i);
  end

  // S1: capture match lines and tag on accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_lines <= '0;
      s1_tag   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_lines <= srch_match_lines;
        s1_tag   <= srch_tag;
      end
    end
  end

  // S2: register the priority-encode result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      s2_hit   <= 1'b0;
      s2_multi <= 1'b0;
      s2_addr  <= '0;
      s2_tag   <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_hit   <= enc_hit;
        s2_multi <= enc_multi;
        s2_addr  <= enc_addr;
        s2_tag   <= s1_tag;
      end
    end
  end

  // FIFO storage; contents need no reset because outputs are gated by res_valid.
  always_ff @(posedge clk) begin
    if (s2_valid) mem[wr_ptr] <= {s2_hit, s2_addr, s2_multi, s2_tag};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (s2_valid) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(s2_valid) - (PW+1)'(pop);
    end
  end

  // Saturating statistics, counted at the FIFO write; clear takes priority over increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (stats_clear) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (s2_valid) begin
      if (s2_hit && !(&hit_count)) hit_count <= hit_count + CNT_WIDTH'(1);
      if (!s2_hit && !(&miss_count)) miss_count <= miss_count + CNT_WIDTH'(1);
    end
  end
endmodule
